// File: rtl/tsn_csr_initiator.sv
// Avalon-MM master issuing single CSR reads/writes for a command/response port,
// with a bounded bus phase so a missing or hung slave produces an error response.
module tsn_csr_initiator #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [15:0]           timeout_cnt_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  write_o,
    output logic                  read_o,
    output logic [DATA_WIDTH-1:0] writedata_o,
    input  logic                  waitrequest_i,
    input  logic [DATA_WIDTH-1:0] readdata_i,
    input  logic                  readdatavalid_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RSP} state_t;

    state_t                state, state_nxt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [15:0]           tcnt_q;

    logic accepted, in_bus, done_wr, done_rd, timeout;

    // Completion in the last counted cycle wins over the timeout.
    always_comb begin
        accepted  = (state == REQ) && !waitrequest_i;
        in_bus    = (state == REQ) || (state == WAIT_RD);
        done_wr   = accepted && wr_q;
        done_rd   = (accepted && !wr_q && readdatavalid_i) ||
                    ((state == WAIT_RD) && readdatavalid_i);
        timeout   = in_bus && (cnt_q == CNT_LAST) && !done_wr && !done_rd;
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nxt = REQ;
            REQ: begin
                if (done_wr || done_rd || timeout) state_nxt = RSP;
                else if (accepted)                 state_nxt = WAIT_RD;
            end
            WAIT_RD: if (done_rd || timeout) state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && cmd_valid_i) begin
                wr_q    <= cmd_write_i;
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                cnt_q   <= '0;
            end else if (in_bus) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (done_rd) begin
                rdata_q <= readdata_i;
                err_q   <= 1'b0;
            end else if (done_wr) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
            end
        end
    end

    // cmd_ready is gated by rst so it reads 0 for the whole reset window.
    assign cmd_ready_o   = (state == IDLE) && !rst;
    assign read_o        = (state == REQ) && !wr_q;
    assign write_o       = (state == REQ) && wr_q;
    assign address_o     = addr_q;
    assign writedata_o   = wdata_q;
    assign rsp_valid_o   = (state == RSP);
    assign rsp_rdata_o   = (state == RSP) ? rdata_q : '0;
    assign rsp_err_o     = (state == RSP) && err_q;
    assign timeout_cnt_o = tcnt_q;
endmodule

// File: tb/tb_tsn_csr_initiator.sv
// Directed bench for tsn_csr_initiator: a table of transactions against a
// scripted slave, plus reset sequences.
module tb_tsn_csr_initiator;
    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] timeout_cnt;
    logic [15:0] address;
    logic        write, read;
    logic [31:0] writedata;
    logic        waitrequest, readdatavalid;
    logic [31:0] readdata;

    int checks   = 0;
    int failures = 0;

    tsn_csr_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .timeout_cnt_o(timeout_cnt),
        .address_o(address), .write_o(write), .read_o(read), .writedata_o(writedata),
        .waitrequest_i(waitrequest), .readdata_i(readdata), .readdatavalid_i(readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          wait_n;     // request cycles with waitrequest high
        int          rdv_delay;  // cycles from acceptance to readdatavalid
        logic        early;      // junk readdatavalid while stalled
        logic [31:0] rdata;
        int          exp_req;    // cycles read_o/write_o high
        int          exp_lat;    // command cycle to rsp_valid cycle
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_tcnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   req_n, accept_k, rsp_k;
        logic stable_ok;
        @(negedge clk);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        req_n = 0; accept_k = -1; rsp_k = -1; stable_ok = 1'b1;
        for (int k = 1; k <= 200 && rsp_k < 0; k++) begin
            @(negedge clk);
            cmd_valid     = 1'b0;
            cmd_write     = 1'b0;
            cmd_addr      = 16'hFFFF;
            cmd_wdata     = 32'hFFFF_FFFF;
            waitrequest   = 1'b1;
            readdatavalid = 1'b0;
            readdata      = 32'hBAD0_BAD0;
            if (rsp_valid) begin
                rsp_k = k;
                check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
                check({tag, "_err"}, 32'(rsp_err), 32'(v.exp_err));
            end else if (read || write) begin
                if (write !== v.wr || read !== !v.wr || address !== v.addr ||
                    (v.wr && writedata !== v.wdata))
                    stable_ok = 1'b0;
                waitrequest = (req_n < v.wait_n);
                req_n++;
                if (!waitrequest) accept_k = k;
                else if (v.early) begin
                    readdatavalid = 1'b1;
                    readdata      = 32'hDEAD_0000;
                end
            end
            if (!v.wr && accept_k > 0 && k == accept_k + v.rdv_delay) begin
                readdatavalid = 1'b1;
                readdata      = v.rdata;
            end
        end
        if (rsp_k < 0) begin
            failures++;
            checks++;
            $display("FAIL %s_no_response: no rsp_valid within 200 cycles", tag);
        end else begin
            check({tag, "_latency"}, 32'(rsp_k), 32'(v.exp_lat));
        end
        check({tag, "_req_cycles"}, 32'(req_n), 32'(v.exp_req));
        check({tag, "_bus_stable"}, 32'(stable_ok), 32'd1);
        @(negedge clk);
        readdatavalid = 1'b0;
        waitrequest   = 1'b1;
        check({tag, "_single_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        check({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'(v.exp_tcnt));
    endtask

    vec_t vecs[11];
    vec_t wv;
    logic quiet_ok;

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 1,    0,  1'b0, 32'h0,        2,  3,  32'h0,        1'b0, 16'd0};
        vecs[1]  = '{1'b0, 16'h0020, 32'h0,        1,    0,  1'b0, 32'h0,        2,  3,  32'h0,        1'b0, 16'd0};
        vecs[2]  = '{1'b0, 16'h0030, 32'h0,        0,    4,  1'b0, 32'h12345678, 1,  6,  32'h12345678, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 16'h0044, 32'h01020304, 0,    0,  1'b0, 32'h0,        1,  2,  32'h0,        1'b0, 16'd0};
        vecs[4]  = '{1'b0, 16'h0050, 32'h0,        2,    0,  1'b1, 32'hCAFEF00D, 3,  4,  32'hCAFEF00D, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 16'h0060, 32'h0,        1000, 0,  1'b0, 32'h0,        64, 65, 32'h0,        1'b1, 16'd1};
        vecs[6]  = '{1'b1, 16'h0064, 32'h55AA55AA, 1000, 0,  1'b0, 32'h0,        64, 65, 32'h0,        1'b1, 16'd2};
        vecs[7]  = '{1'b0, 16'h0070, 32'h0,        0,    63, 1'b0, 32'hA5A5A5A5, 1,  65, 32'hA5A5A5A5, 1'b0, 16'd2};
        vecs[8]  = '{1'b0, 16'h0074, 32'h0,        63,   0,  1'b0, 32'h5A5A0F0F, 64, 65, 32'h5A5A0F0F, 1'b0, 16'd2};
        vecs[9]  = '{1'b0, 16'h0078, 32'h0,        0,    64, 1'b0, 32'h77777777, 1,  65, 32'h0,        1'b1, 16'd3};
        vecs[10] = '{1'b1, 16'h007C, 32'h13579BDF, 63,   0,  1'b0, 32'h0,        64, 65, 32'h0,        1'b0, 16'd3};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        waitrequest = 1'b1; readdatavalid = 1'b0; readdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
        check("rst_read_low", 32'(read), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("post_rst_rsp_err", 32'(rsp_err), 32'd0);
        check("post_rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("post_rst_rw", {30'd0, read, write}, 32'd0);
        check("post_rst_address", 32'(address), 32'd0);
        check("post_rst_writedata", writedata, 32'd0);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for read data.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0080;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rstwait_read_high", 32'(read), 32'd1);
        waitrequest = 1'b0;
        @(negedge clk);
        waitrequest = 1'b1;
        check("rstwait_in_wait_rd", {30'd0, read, write}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstwait_rw_low", {30'd0, read, write}, 32'd0);
        check("rstwait_no_rsp", 32'(rsp_valid), 32'd0);
        check("rstwait_ready_in_rst", 32'(cmd_ready), 32'd0);
        check("rstwait_tcnt_cleared", 32'(timeout_cnt), 32'd0);
        rst = 1'b0;
        quiet_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || read !== 1'b0) quiet_ok = 1'b0;
        end
        check("rstwait_quiet_idle", 32'(quiet_ok), 32'd1);
        wv = '{1'b1, 16'h0090, 32'hFEEDFACE, 0, 0, 1'b0, 32'h0, 1, 2, 32'h0, 1'b0, 16'd0};
        run_txn(wv, "after_rst_write");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
